// File: rtl/perm_shift_pipe.sv
// perm_shift_pipe: quadword shift/rotate unit behind a STAGES-deep, stallable, flushable pipeline.
// Rotate ops (3 ROTQBY, 4 ROTQBI, 5 ROTQMBY) are built only when PERM_SHIFT_ROTATE_EN is defined.
module perm_shift_pipe #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAGW   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [0:WIDTH-1] ra,
  input  logic [0:WIDTH-1] rb,
  input  logic [TAGW-1:0]  tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] result,
  output logic [TAGW-1:0]  tag_out,
  output logic             err
);
  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned CW = LW + 1;

  logic [CW-1:0]    cnt_by;
  logic [CW-1:0]    cnt_cb;
  logic [2:0]       cnt_bi;
  logic [0:WIDTH-1] res_c;
  logic             err_c;
  logic             unused_rb;

  // Counts live in the low bits of big-endian word 0 (bit 31 is the LSB).
  assign cnt_by    = rb[32-CW:31];
  assign cnt_cb    = rb[29-CW:28];
  assign cnt_bi    = rb[29:31];
  assign unused_rb = ^{rb[0:28-CW], rb[32:WIDTH-1]};

`ifdef PERM_SHIFT_ROTATE_EN
  logic [CW-1:0]      cnt_neg;
  logic [0:2*WIDTH-1] rot_by_c;
  logic [0:2*WIDTH-1] rot_bi_c;

  // Rotates are taken from the top half of a doubled word shifted left.
  assign cnt_neg  = -cnt_by;
  assign rot_by_c = {ra, ra} << {cnt_by[LW-1:0], 3'b000};
  assign rot_bi_c = {ra, ra} << cnt_bi;
`endif

  // Operation datapath, evaluated on the cycle of acceptance.
  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (op)
      3'd0: res_c = (cnt_by >= CW'(NB)) ? '0 : ra << {cnt_by, 3'b000};
      3'd1: res_c = ra << cnt_bi;
      3'd2: res_c = (cnt_cb >= CW'(NB)) ? '0 : ra << {cnt_cb, 3'b000};
`ifdef PERM_SHIFT_ROTATE_EN
      3'd3: res_c = rot_by_c[0:WIDTH-1];
      3'd4: res_c = rot_bi_c[0:WIDTH-1];
      3'd5: res_c = (cnt_neg >= CW'(NB)) ? '0 : ra >> {cnt_neg, 3'b000};
`endif
      default: err_c = 1'b1;
    endcase
  end

  logic             vld_q [STAGES];
  logic [0:WIDTH-1] res_q [STAGES];
  logic [TAGW-1:0]  tag_q [STAGES];
  logic             err_q [STAGES];

  // Whole pipeline advances together; only a blocked output stalls it.
  assign in_ready = !(out_valid && !out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        vld_q[i] <= 1'b0;
        res_q[i] <= '0;
        tag_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        vld_q[i] <= 1'b0;
      end
    end else if (in_ready) begin
      vld_q[0] <= in_valid;
      res_q[0] <= res_c;
      tag_q[0] <= tag_in;
      err_q[0] <= err_c;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
        tag_q[i] <= tag_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign tag_out   = tag_q[STAGES-1];
  assign err       = err_q[STAGES-1];

endmodule

// File: tb/tb_perm_shift_pipe.sv
// Directed bench for perm_shift_pipe: op results, count boundaries, latency, stall, flush, reset.
module tb_perm_shift_pipe;
  localparam int unsigned W   = 128;
  localparam int unsigned TW  = 7;
  localparam int unsigned LAT = 3;
  localparam logic [0:W-1] RA  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [0:W-1] RA2 = 128'hF0000000_00000000_00000000_00000001;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [0:W-1]  ra;
  logic [0:W-1]  rb;
  logic [TW-1:0] tag_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [0:W-1]  result;
  logic [TW-1:0] tag_out;
  logic          err;

  int n_checks;
  int n_fail;

  perm_shift_pipe #(.WIDTH(W), .STAGES(LAT), .TAGW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .tag_in   (tag_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .tag_out  (tag_out),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an empty pipe and check latency, result, err and tag.
  task automatic single(input string name, input logic [2:0] o, input logic [0:W-1] a,
                        input logic [31:0] w0, input logic [0:W-1] exp_res,
                        input logic exp_err, input logic [TW-1:0] t);
    int n;
    op = o; ra = a; rb = {w0, 96'h0}; tag_in = t; in_valid = 1'b1;
    #1;
    check({name, " rdy"}, W'(in_ready), W'(1));
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    check({name, " lat"}, W'(n), W'(LAT));
    check({name, " res"}, result, exp_res);
    check({name, " err"}, W'(err), W'(exp_err));
    check({name, " tag"}, W'(tag_out), W'(t));
    tick;
  endtask

  initial begin
    int exp_t;
    int nxt;
    int seen;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    op = 3'd0; ra = '0; rb = '0; tag_in = '0;
    tick; tick; tick;
    check("reset vld", W'(out_valid), W'(0));
    check("reset res", result, W'(0));
    check("reset tag", W'(tag_out), W'(0));
    check("reset err", W'(err), W'(0));
    rst = 1'b0;
    #1;
    check("reset rdy", W'(in_ready), W'(1));

    single("shl3",     3'd0, RA, 32'd3,    128'h33445566_778899AA_BBCCDDEE_FF000000, 1'b0, 7'd1);
    single("shl16",    3'd0, RA, 32'd16,   128'h0, 1'b0, 7'd2);
    single("shl0",     3'd0, RA, 32'd0,    RA, 1'b0, 7'd3);
    single("shlbi4",   3'd1, RA, 32'd4,    128'h01122334_45566778_899AABBC_CDDEEFF0, 1'b0, 7'd4);
    single("shlbybi2", 3'd2, RA, 32'h10,   128'h22334455_66778899_AABBCCDD_EEFF0000, 1'b0, 7'd5);
    single("shlbyb16", 3'd2, RA, 32'h80,   128'h0, 1'b0, 7'd6);
    single("ill7",     3'd7, RA, 32'd3,    128'h0, 1'b1, 7'd7);
    single("ill6",     3'd6, RA, 32'd3,    128'h0, 1'b1, 7'd8);
`ifdef PERM_SHIFT_ROTATE_EN
    single("rot17",    3'd3, RA, 32'd17,   128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b0, 7'd9);
    single("rotbi4",   3'd4, RA2, 32'd4,   128'h00000000_00000000_00000000_0000001F, 1'b0, 7'd10);
    single("rotm2",    3'd5, RA, 32'hFFFFFFFE, 128'h00000011_22334455_66778899_AABBCCDD, 1'b0, 7'd11);
`else
    single("rot3 ill", 3'd3, RA, 32'd17,   128'h0, 1'b1, 7'd9);
    single("rot4 ill", 3'd4, RA, 32'd4,    128'h0, 1'b1, 7'd10);
    single("rot5 ill", 3'd5, RA, 32'hFFFFFFFE, 128'h0, 1'b1, 7'd11);
`endif

    // Five back-to-back ops, output blocked in cycles 4 and 5.
    nxt = 1; exp_t = 1;
    for (int cyc = 0; cyc < 40 && exp_t <= 5; cyc++) begin
      in_valid = (nxt <= 5); op = 3'd0; ra = RA;
      rb = {32'(nxt), 96'h0}; tag_in = TW'(nxt);
      out_ready = !(cyc == 4 || cyc == 5);
      #1;
      if (cyc == 4 || cyc == 5) begin
        check("stall rdy", W'(in_ready), W'(0));
        check("stall tag", W'(tag_out), W'(2));
        check("stall res", result, RA << 16);
      end
      if (out_valid && out_ready) begin
        if (exp_t == 1) check("stall lat", W'(cyc), W'(LAT));
        check("stall order", W'(tag_out), W'(exp_t));
        check("stall data", result, RA << (8 * exp_t));
        exp_t++;
      end
      if (in_valid && in_ready) nxt++;
      tick;
    end
    check("stall done", W'(exp_t), W'(6));
    in_valid = 1'b0; out_ready = 1'b1;

    // Flush with two ops in flight and a third offered in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 3'd0; ra = RA; rb = '0; tag_in = TW'(8 + i);
      flush = (i == 2);
      tick;
    end
    in_valid = 1'b0; flush = 1'b0;
    check("flush vld", W'(out_valid), W'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) seen++;
    end
    check("flush drain", W'(seen), W'(0));

    // Reset with two ops in flight.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op = 3'd0; ra = RA; rb = {32'd1, 96'h0}; tag_in = TW'(20 + i);
      tick;
    end
    in_valid = 1'b0; rst = 1'b1;
    tick;
    check("rst vld", W'(out_valid), W'(0));
    check("rst res", result, W'(0));
    check("rst tag", W'(tag_out), W'(0));
    check("rst err", W'(err), W'(0));
    rst = 1'b0;
    #1;
    check("rst rdy", W'(in_ready), W'(1));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) seen++;
    end
    check("rst drain", W'(seen), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perm_shift_pipe.md
PERM_SHIFT_PIPE -- requirements
Module: perm_shift_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the quadword width in bits; it SHALL be a power of two and at least 16.
REQ-002 The block SHALL have parameter STAGES, default 3, giving the pipeline latency in cycles; it SHALL be at least 1.
REQ-003 The block SHALL have parameter TAGW, default 7, giving the width of the destination-register tag.
REQ-004 Port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: an operation is offered.
REQ-007 Port in_ready, output, 1 bit: the block accepts the offered operation this cycle.
REQ-008 Port op, input, 3 bits: operation select (see REQ-015).
REQ-009 Port ra, input, [0:WIDTH-1]: source quadword, big-endian, byte 0 at bits [0:7].
REQ-010 Port rb, input, [0:WIDTH-1]: count word; only word 0 (bits [0:31]) is used.
REQ-011 Port tag_in, input, TAGW bits: destination tag, carried with the operation.
REQ-012 Port flush, input, 1 bit: discard every operation in flight.
REQ-013 Ports out_valid (output, 1), out_ready (input, 1), result (output, [0:WIDTH-1]), tag_out (output, TAGW) and err (output, 1): the result channel.

Function
REQ-014 Definitions used below:
- N = WIDTH/8 bytes.
- C = clog2(N)+1 bits.
- Byte count cb = rb[32-C-3 : 31-3], i.e. C bits ending at bit 28.
- Bit count ci = rb[29:31].
REQ-015 The op encodings SHALL be:
- 0 SHLQBY: left shift by rb[32-C:31] bytes, with zero fill.
- 1 SHLQBI: left shift by ci bits, with zero fill.
- 2 SHLQBYBI: left shift by cb bytes, with zero fill.
- 3 ROTQBY: rotate left by rb[32-C:31] mod N bytes.
- 4 ROTQBI: rotate left by ci bits.
- 5 ROTQMBY: logical right shift by the two's-complement negation of rb[32-C:31] bytes, with zero fill.
- 6–7: illegal.
REQ-016 For zero-fill byte shifts, a count of N or more SHALL give an all-zero result, and a count of 0 SHALL return ra unchanged.
REQ-017 An illegal op SHALL produce result 0 with err=1; every legal op SHALL produce err=0.
REQ-018 in_ready SHALL equal !(out_valid && !out_ready), i.e. the whole pipeline stalls together.
REQ-019 Transfer rules:
- An operation is accepted when in_valid && in_ready.
- An operation is delivered when out_valid && out_ready.
REQ-020 An operation accepted in cycle t SHALL appear on out_valid in cycle t+STAGES, provided no stall intervenes; each stall cycle adds one cycle.
REQ-021 While stalled, result, tag_out and err SHALL hold stable, and the internal stages SHALL not advance.
REQ-022 Each stage SHALL hold a valid bit; bubbles SHALL propagate, and out_valid SHALL be 0 for a bubble.
REQ-023 When flush=1 in cycle t, every stage valid bit SHALL be 0 in cycle t+1, and nothing offered in cycle t SHALL be accepted.
- in_ready MAY still be 1 during the flush cycle.
- flush SHALL take precedence over in_valid and over any stall.
REQ-024 Back-to-back operations SHALL sustain a throughput of one per cycle while out_ready=1.
REQ-025 tag_out SHALL always be the tag_in of the operation whose result is presented.

Reset
REQ-026 When rst=1 at a clock edge, all stage valid bits, out_valid, result, tag_out and err SHALL be 0 in the next cycle.
REQ-027 rst SHALL take precedence over flush, in_valid and stall; any operation in flight SHALL be discarded.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-029 Macro PERM_SHIFT_ROTATE_EN SHALL control the rotate operations.
- Defined: ops 3, 4 and 5 behave per REQ-015.
- Undefined: ops 3, 4 and 5 are treated as illegal per REQ-017, and the rotate datapath is not synthesised.
- Latency and handshake SHALL be identical in both builds.

Verification
REQ-030 Zero-fill shift: WIDTH=128, op=0, ra=0x00112233445566778899AABBCCDDEEFF, rb word0=3 -> after 3 cycles, result=0x33445566778899AABBCCDDEEFF000000, err=0.
REQ-031 Shift count boundaries: op=0 with rb word0=16 -> result=0; with rb word0=0 -> result=ra.
REQ-032 Rotate and rotate-mask (macro defined): op=3, same ra, rb word0=17 -> result=0x112233445566778899AABBCCDDEEFF00. op=5, rb word0=0xFFFFFFFE (count 2) -> result=0x000000112233445566778899AABBCCDD.
REQ-033 Stall and flush:
- Issue 5 operations back-to-back, tags 1 to 5, with out_ready=0 from cycle 4 for 2 cycles -> tags appear in order 1 to 5, outputs are held during the stall, and in_ready=0 during the stall.
- Then flush mid-stream -> no further out_valid.
REQ-034 Illegal op and reset:
- op=7 -> result=0, err=1.
- Macro undefined, op=3 -> err=1.
- rst asserted with 2 operations in flight -> out_valid=0 next cycle, and neither operation is ever delivered.
